// File: rtl/map_lookup_arbiter_if.sv
// ----------------------------------------------------------------------------
// map_lookup_arbiter_if : requester, result and map-ROM signals of the lookup
// arbiter bundled for port connection.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface map_lookup_arbiter_if #(
  parameter int NREQ = 4,
  parameter int COLS = 80
);
  logic                 map_sel;
  logic [NREQ-1:0]      req;
  logic [7*NREQ-1:0]    tile_x;
  logic [6*NREQ-1:0]    tile_y;
  logic [NREQ-1:0]      ack;
  logic                 wall;
  logic                 busy;
  logic [10:0]          rom_addr;
  logic [COLS-1:0]      rom_data;

  // The arbiter is the slave; requesters and the ROM sit on the master side.
  modport slave (
    input  map_sel, req, tile_x, tile_y, rom_data,
    output ack, wall, busy, rom_addr
  );

  modport master (
    output map_sel, req, tile_x, tile_y, rom_data,
    input  ack, wall, busy, rom_addr
  );
endinterface

`default_nettype wire

// File: rtl/map_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// map_lookup_arbiter : round-robin arbiter serialising wall lookups from the
// player/enemy cars into a single combinational tile-map ROM.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module map_lookup_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAP1_BASE = 70,
  parameter int ROWS      = 60,
  parameter int COLS      = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  map_lookup_arbiter_if.slave  bus
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_LOOKUP = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  localparam logic [PW-1:0]  c_LAST      = PW'(NREQ - 1);
  localparam logic [PW1-1:0] c_NREQ      = PW1'(NREQ);
  localparam logic [7:0]     c_COLS      = 8'(COLS);
  localparam logic [6:0]     c_ROWS      = 7'(ROWS);
  localparam logic [6:0]     c_COL_MAX   = 7'(COLS - 1);
  localparam logic [10:0]    c_MAP1_BASE = 11'(MAP1_BASE);

  logic [1:0]     r_state;
  logic [PW-1:0]  r_rr_ptr;
  logic [PW-1:0]  r_grant;
  logic [6:0]     r_x;
  logic           r_wall;
  logic [10:0]    r_rom_addr;

  logic           w_found;
  logic [PW-1:0]  w_gnt;
  logic [PW1-1:0] w_sum;
  logic [PW-1:0]  w_cand;
  logic [6:0]     w_sel_x;
  logic [5:0]     w_sel_y;
  logic           w_in_range;
  logic [10:0]    w_addr;
  logic [6:0]     w_col;

  // Scan requesters starting at rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + PW1'(k);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_gnt   = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == PW'(i)) begin
        w_sel_x = bus.tile_x[7*i +: 7];
        w_sel_y = bus.tile_y[6*i +: 6];
      end
    end
  end

  assign w_in_range = ({1'b0, w_sel_x} < c_COLS) && ({1'b0, w_sel_y} < c_ROWS);
  assign w_addr     = (bus.map_sel ? c_MAP1_BASE : 11'd0) + {5'd0, w_sel_y};
  // Column 0 is the MSB of the ROM row.
  assign w_col      = c_COL_MAX - r_x;

  // The map choice is folded into rom_addr at grant time, so later map_sel
  // changes cannot disturb an in-flight lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_x        <= '0;
      r_wall     <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant <= w_gnt;
            r_x     <= w_sel_x;
            if (w_in_range) begin
              r_rom_addr <= w_addr;
              r_state    <= c_LOOKUP;
            end else begin
              r_wall  <= 1'b1;
              r_state <= c_RESP;
            end
          end
        end
        c_LOOKUP: begin
          r_wall  <= bus.rom_data[w_col];
          r_state <= c_RESP;
        end
        c_RESP: begin
          r_rr_ptr <= (r_grant == c_LAST) ? '0 : r_grant + PW'(1);
          r_state  <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.ack[i] = (r_state == c_RESP) && (r_grant == PW'(i));
    end
  end

  assign bus.wall     = r_wall;
  assign bus.busy     = (r_state != c_IDLE);
  assign bus.rom_addr = r_rom_addr;

endmodule

`default_nettype wire

// File: tb/tb_map_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// tb_map_lookup_arbiter : directed bench for map_lookup_arbiter with a
// scoreboard of expected (requester, wall) responses.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_map_lookup_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_lookup_arbiter_if #(.NREQ(4), .COLS(80)) bus ();

  map_lookup_arbiter #(
    .NREQ(4), .MAP1_BASE(70), .ROWS(60), .COLS(80)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM image: border rows are solid walls, other rows a diagonal pattern.
  function automatic logic [79:0] rom_row(input logic [10:0] a);
    logic [79:0] row;
    int ai;
    ai = int'(a);
    for (int b = 0; b < 80; b++) begin
      row[b] = ((ai * 3 + b) % 4) == 0;
    end
    if (ai == 0 || ai == 59 || ai == 70 || ai == 129) row = '1;
    return row;
  endfunction

  assign bus.rom_data = rom_row(bus.rom_addr);

  typedef struct {
    int   idx;
    logic wall;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [10:0] exp_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_wall(input logic [10:0] a, input int x);
    logic [79:0] row;
    row = rom_row(a);
    return row[79 - x];
  endfunction

  // Response monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack !== 4'b0000) begin
      check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
      check("ack_busy", 32'(bus.busy), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_idx", 32'(bus.ack), 32'(1 << e.idx));
        check("ack_wall", 32'(bus.wall), 32'(e.wall));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic set_tiles(input int x, input int y);
    for (int i = 0; i < 4; i++) begin
      bus.tile_x[7*i +: 7] = 7'(x);
      bus.tile_y[6*i +: 6] = 6'(y);
    end
  endtask

  task automatic lookup(input logic [3:0] mask, input int idx, input int x,
                        input int y, input logic map, input logic flip_map);
    logic [10:0] ea;
    logic        ew;
    bit          inr;
    int          lat;
    wait_idle();
    inr = (x < 80) && (y < 60);
    ea  = inr ? 11'((map ? 70 : 0) + y) : exp_addr;
    ew  = inr ? exp_wall(ea, x) : 1'b1;
    set_tiles(x, y);
    bus.map_sel = map;
    bus.req     = mask;
    sb.push_back('{idx, ew});
    @(posedge clk); #1;
    lat = 1;
    check("grant_busy", 32'(bus.busy), 32'd1);
    check("rom_addr", 32'(bus.rom_addr), 32'(ea));
    bus.req = '0;
    if (flip_map) bus.map_sel = ~map;
    while (bus.ack[idx] !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), inr ? 32'd2 : 32'd1);
    check("rom_addr_resp", 32'(bus.rom_addr), 32'(ea));
    @(posedge clk); #1;
    check("ack_cleared", 32'(bus.ack), 32'd0);
    check("wall_hold", 32'(bus.wall), 32'(ew));
    check("busy_cleared", 32'(bus.busy), 32'd0);
    exp_addr = ea;
  endtask

  initial begin
    int c0;
    int n;
    bus.map_sel = 1'b0;
    bus.req     = '0;
    bus.tile_x  = '0;
    bus.tile_y  = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_wall", 32'(bus.wall), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst = 1'b0;

    lookup(4'b0001, 0, 3, 3, 1'b0, 1'b0);    // row 3, bit 76
    lookup(4'b0100, 2, 0, 0, 1'b1, 1'b0);    // map 1 border row
    lookup(4'b0010, 1, 80, 5, 1'b0, 1'b0);   // column out of range
    lookup(4'b1000, 3, 10, 5, 1'b0, 1'b1);   // map_sel flipped mid-flight
    lookup(4'b0001, 0, 20, 60, 1'b1, 1'b0);  // row out of range
    lookup(4'b0100, 2, 79, 57, 1'b1, 1'b0);  // last column

    // Round robin with all requests held from reset.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_addr = '0;
    bus.map_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.tile_x[7*i +: 7] = 7'(10 + 3 * i);
      bus.tile_y[6*i +: 6] = 6'(1 + 7 * i);
    end
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{k % 4, exp_wall(11'(1 + 7 * (k % 4)), 10 + 3 * (k % 4))});
    end
    c0 = cyc;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (bus.ack === 4'b0000 && n < 6);
      check("rr_ack_cycle", 32'(cyc - c0), 32'(2 + 3 * k));
    end
    bus.req = '0;

    // Reset in LOOKUP aborts the lookup; rr_ptr is 1 before the abort.
    wait_idle();
    set_tiles(12, 9);
    bus.req = 4'b0100;
    @(posedge clk); #1;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ack", 32'(bus.ack), 32'd0);
    check("abort_wall", 32'(bus.wall), 32'd0);
    check("abort_rom_addr", 32'(bus.rom_addr), 32'd0);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_addr = '0;
    lookup(4'b1001, 0, 12, 9, 1'b0, 1'b0);

    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
